// File: rtl/fpusb_pkg.sv
// Shared constants, state encoding and status helper for the FTDI <-> FPU frame codec.
package fpusb_pkg;

  localparam logic [7:0]  SYNC_REQ      = 8'hA5;
  localparam logic [7:0]  SYNC_RSP      = 8'h5A;
  localparam int unsigned REQ_LEN       = 10;
  localparam int unsigned RSP_LEN       = 7;
  localparam int unsigned STATUS_BAD_OP = 7;
  localparam int unsigned FLAG_W        = 5;

  typedef enum logic [2:0] {
    ST_HUNT     = 3'd0,
    ST_RX_OP    = 3'd1,
    ST_RX_A     = 3'd2,
    ST_RX_B     = 3'd3,
    ST_CHECK    = 3'd4,
    ST_ISSUE    = 3'd5,
    ST_WAIT_RES = 3'd6,
    ST_TX       = 3'd7
  } state_t;

  // Response status byte: {bad_op, 2'b00, flags[4:0]}.
  function automatic logic [7:0] make_status(input logic bad_op, input logic [FLAG_W-1:0] flags);
    logic [7:0] s;
    s                = '0;
    s[FLAG_W-1:0]    = flags;
    s[STATUS_BAD_OP] = bad_op;
    return s;
  endfunction

endpackage

// File: rtl/fpu_rsp_serializer.sv
// Emits one RSP_LEN-byte response frame, MSB byte first, honouring TX FIFO back-pressure.
module fpu_rsp_serializer
  import fpusb_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [7:0]  op,
  input  logic [31:0] res,
  input  logic [7:0]  status,
  input  logic        full,
  output logic        push,
  output logic [7:0]  data,
  output logic        done
);

  localparam int unsigned FRAME_W = RSP_LEN * 8;

  logic [FRAME_W-1:0] frame_q;
  logic [2:0]         idx_q;
  logic               active_q;

  // Frame shift register and byte index; a full FIFO holds both in place.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_q  <= '0;
      idx_q    <= '0;
      active_q <= 1'b0;
    end else if (load) begin
      frame_q  <= {SYNC_RSP, op, res, status};
      idx_q    <= '0;
      active_q <= 1'b1;
    end else if (active_q && !full) begin
      frame_q <= frame_q << 8;
      if (idx_q == 3'(RSP_LEN - 1)) begin
        idx_q    <= '0;
        active_q <= 1'b0;
      end else begin
        idx_q <= idx_q + 3'd1;
      end
    end
  end

  // Current head byte is presented whenever the frame is being sent.
  always_comb begin
    push = active_q && !full;
    data = active_q ? frame_q[FRAME_W-1 -: 8] : '0;
    done = push && (idx_q == 3'(RSP_LEN - 1));
  end

endmodule

// File: rtl/fpu_frame_codec.sv
// Request parser / FPU issuer / response framer between the FTDI byte FIFOs and the FPU core.
module fpu_frame_codec
  import fpusb_pkg::*;
#(
  parameter int unsigned NUM_OPS        = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic              clk_pll,
  input  logic              reset,
  input  logic [7:0]        FIFO_output_data,
  input  logic              FIFO_empty,
  output logic              FIFO_pop_data,
  output logic [7:0]        FIFO_input_data,
  output logic              FIFO_push_data,
  input  logic              FIFO_full,
  output logic [7:0]        fpu_op,
  output logic [31:0]       fpu_a,
  output logic [31:0]       fpu_b,
  output logic              fpu_req_valid,
  input  logic              fpu_req_ready,
  input  logic [31:0]       fpu_res,
  input  logic [FLAG_W-1:0] fpu_res_flags,
  input  logic              fpu_res_valid,
  output logic              fpu_res_ready,
  output logic              frame_error,
  output logic              busy
);

  localparam int unsigned IDLE_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = (TIMEOUT_CYCLES == 0) ? '0 : IDLE_W'(TIMEOUT_CYCLES - 1);

  state_t            state_q, state_d;
  logic [7:0]        op_q;
  logic [31:0]       a_q, b_q;
  logic [1:0]        cnt_q;
  logic [IDLE_W-1:0] idle_q;

  logic              rx_state, in_frame, pop, timeout_hit;
  logic              ser_load, ser_push, ser_done;
  logic [31:0]       ser_res;
  logic [7:0]        ser_status, ser_data;

  // Pop qualification and mid-frame idle timeout detection.
  always_comb begin
    rx_state    = state_q inside {ST_HUNT, ST_RX_OP, ST_RX_A, ST_RX_B};
    in_frame    = state_q inside {ST_RX_OP, ST_RX_A, ST_RX_B};
    pop         = rx_state && !FIFO_empty;
    timeout_hit = (TIMEOUT_CYCLES != 0) && in_frame && !pop && (idle_q == IDLE_LAST);
  end

  // Next-state logic; also selects what gets loaded into the response serializer.
  always_comb begin
    state_d    = state_q;
    ser_load   = 1'b0;
    ser_res    = '0;
    ser_status = '0;
    case (state_q)
      ST_HUNT: begin
        if (pop && FIFO_output_data == SYNC_REQ) state_d = ST_RX_OP;
      end
      ST_RX_OP: begin
        if (pop)              state_d = ST_RX_A;
        else if (timeout_hit) state_d = ST_HUNT;
      end
      ST_RX_A: begin
        if (pop && cnt_q == 2'd3) state_d = ST_RX_B;
        else if (timeout_hit)     state_d = ST_HUNT;
      end
      ST_RX_B: begin
        if (pop && cnt_q == 2'd3) state_d = ST_CHECK;
        else if (timeout_hit)     state_d = ST_HUNT;
      end
      ST_CHECK: begin
        if (32'(op_q) < NUM_OPS) begin
          state_d = ST_ISSUE;
        end else begin
          state_d    = ST_TX;
          ser_load   = 1'b1;
          ser_status = make_status(1'b1, '0);
        end
      end
      ST_ISSUE: begin
        if (fpu_req_ready) state_d = ST_WAIT_RES;
      end
      ST_WAIT_RES: begin
        if (fpu_res_valid) begin
          state_d    = ST_TX;
          ser_load   = 1'b1;
          ser_res    = fpu_res;
          ser_status = make_status(1'b0, fpu_res_flags);
        end
      end
      ST_TX: begin
        if (ser_done) state_d = ST_HUNT;
      end
      default: state_d = ST_HUNT;
    endcase
  end

  // State register, request field capture and idle counter.
  always_ff @(posedge clk_pll) begin
    if (reset) begin
      state_q <= ST_HUNT;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      if (pop) begin
        case (state_q)
          ST_HUNT:  cnt_q <= '0;
          ST_RX_OP: begin
            op_q  <= FIFO_output_data;
            cnt_q <= '0;
          end
          ST_RX_A: begin
            a_q   <= {a_q[23:0], FIFO_output_data};
            cnt_q <= cnt_q + 2'd1;
          end
          ST_RX_B: begin
            b_q   <= {b_q[23:0], FIFO_output_data};
            cnt_q <= cnt_q + 2'd1;
          end
          default: ;
        endcase
      end
      if (!in_frame || pop || timeout_hit) idle_q <= '0;
      else                                 idle_q <= idle_q + 1'b1;
    end
  end

  fpu_rsp_serializer u_ser (
    .clk    (clk_pll),
    .reset  (reset),
    .load   (ser_load),
    .op     (op_q),
    .res    (ser_res),
    .status (ser_status),
    .full   (FIFO_full),
    .push   (ser_push),
    .data   (ser_data),
    .done   (ser_done)
  );

  // Handshake and strobe outputs are held low for the whole time reset is high.
  always_comb begin
    FIFO_pop_data   = !reset && pop;
    FIFO_push_data  = !reset && ser_push;
    FIFO_input_data = ser_data;
    fpu_op          = op_q;
    fpu_a           = a_q;
    fpu_b           = b_q;
    fpu_req_valid   = !reset && (state_q == ST_ISSUE);
    fpu_res_ready   = !reset && (state_q == ST_WAIT_RES);
    frame_error     = !reset && timeout_hit;
    busy            = !reset && (state_q != ST_HUNT);
  end

endmodule
